debouncer_multi: RTL and testbench

//  N-channel push-button conditioner: 2-FF synchroniser, per-channel debounce, press/release

---
 rtl/debouncer_multi.sv | 140 ++++++++++++++
 tb/tb_debouncer_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// N-channel push-button conditioner: synchroniser, debounce, press/release strobes,
// long-press hold flag and auto-repeat strobes, each channel fully independent.
module debouncer_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int HOLD_CYC   = 50000,
  parameter int REPEAT_CYC = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] PB_in,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_hold,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int HCNT_W = $clog2(HOLD_CYC + 1);
  localparam int RCNT_W = $clog2(REPEAT_CYC + 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);
  localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HELD} hold_state_e;

  logic [N_CH-1:0]   pb_norm;
  logic [N_CH-1:0]   s0_q, s0_d, s1_q, s1_d;
  logic [N_CH-1:0]   state_q, state_d, prev_q, prev_d;
  logic [N_CH-1:0]   press_q, press_d, release_q, release_d;
  logic [N_CH-1:0]   hold_q, hold_d, rpt_q, rpt_d;
  logic [CNT_W-1:0]  cnt_q [N_CH];
  logic [CNT_W-1:0]  cnt_d [N_CH];
  logic [HCNT_W-1:0] hcnt_q [N_CH];
  logic [HCNT_W-1:0] hcnt_d [N_CH];
  logic [RCNT_W-1:0] rcnt_q [N_CH];
  logic [RCNT_W-1:0] rcnt_d [N_CH];
  hold_state_e       fsm_q [N_CH];
  hold_state_e       fsm_d [N_CH];

  // Internally 1 always means pressed, so reset value 0 is the released level.
  assign pb_norm = (ACTIVE_LOW != 0) ? ~PB_in : PB_in;

  always_comb begin
    s0_d      = pb_norm;
    s1_d      = s0_q;
    state_d   = state_q;
    prev_d    = state_q;
    press_d   = state_q & ~prev_q;
    release_d = ~state_q & prev_q;
    hold_d    = hold_q;
    rpt_d     = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = '0;
      fsm_d[i]  = fsm_q[i];
      hcnt_d[i] = hcnt_q[i];
      rcnt_d[i] = rcnt_q[i];

      if (s1_q[i] != state_q[i]) begin
        if (cnt_q[i] == '1) state_d[i] = ~state_q[i];
        else                cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end

      // Release overrides any hold/repeat event falling on the same edge.
      if (!state_q[i]) begin
        fsm_d[i]  = IDLE;
        hold_d[i] = 1'b0;
        hcnt_d[i] = '0;
        rcnt_d[i] = '0;
      end else begin
        case (fsm_q[i])
          IDLE: begin
            fsm_d[i]  = WAIT;
            hcnt_d[i] = '0;
          end
          WAIT: begin
            if (hcnt_q[i] == HOLD_LAST) begin
              fsm_d[i]  = HELD;
              hold_d[i] = 1'b1;
              rpt_d[i]  = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
            end
          end
          HELD: begin
            if (rcnt_q[i] == REP_LAST) begin
              rpt_d[i]  = 1'b1;
              rcnt_d[i] = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
            end
          end
          default: fsm_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q      <= '0;
      s1_q      <= '0;
      state_q   <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      rpt_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        hcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
        fsm_q[i]  <= IDLE;
      end
    end else begin
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      state_q   <= state_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        fsm_q[i]  <= fsm_d[i];
      end
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_hold    = hold_q;
  assign btn_repeat  = rpt_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: table of stimulus windows with a scoreboard of expected
// strobe counts and end levels, plus hand sequences for latency, bounce and reset.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] PB_in = 4'hF;
  logic [3:0] btn_state, btn_press, btn_release, btn_hold, btn_repeat;

  debouncer_multi #(
    .N_CH(4), .CNT_W(4), .ACTIVE_LOW(1), .HOLD_CYC(40), .REPEAT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .PB_in(PB_in),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .btn_hold(btn_hold), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pb;
    int         len;
    int         np;
    int         nr;
    int         nrep;
    logic [3:0] st;
    logic [3:0] hd;
  } vec_t;

  vec_t tbl [9];
  vec_t sbq [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_press = 0, cnt_rel = 0, cnt_rep = 0, both_hi = 0;

  always @(negedge clk) begin
    cnt_press += $countones(btn_press);
    cnt_rel   += $countones(btn_release);
    cnt_rep   += $countones(btn_repeat);
    both_hi   += $countones(btn_press & btn_release);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive pbv, then watch len edges; first edge index where state/press on ch is seen.
  task automatic run_edges(input logic [3:0] pbv, input int len, input int ch,
                           output int ns, output int np, output int npress);
    PB_in  = pbv;
    ns     = -1;
    np     = -1;
    npress = 0;
    for (int n = 1; n <= len; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (btn_state[ch] && ns < 0) ns = n;
      if (btn_press[ch] && np < 0) np = n;
      npress += int'(btn_press[ch]);
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    int   acc, ns, np, npc, nh, r1, r2, ns0, ns2, pr, rl;

    tbl[0] = '{4'hF,  30, 0, 0, 0, 4'h0, 4'h0};
    tbl[1] = '{4'hE,  30, 1, 0, 0, 4'h1, 4'h0};
    tbl[2] = '{4'hF,  30, 0, 1, 0, 4'h0, 4'h0};
    tbl[3] = '{4'hD,  10, 0, 0, 0, 4'h0, 4'h0};
    tbl[4] = '{4'hF,  20, 0, 0, 0, 4'h0, 4'h0};
    tbl[5] = '{4'hB, 120, 1, 0, 7, 4'h4, 4'h4};
    tbl[6] = '{4'hF,  30, 0, 1, 1, 4'h0, 4'h0};
    tbl[7] = '{4'h6,  30, 2, 0, 0, 4'h9, 4'h0};
    tbl[8] = '{4'hF,  30, 0, 2, 0, 4'h0, 4'h0};

    // Reset with all buttons released, then 100 quiet clocks.
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", int'({btn_state, btn_press, btn_release, btn_hold, btn_repeat}), 0);
    @(negedge clk);
    rst = 1'b0;
    acc = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      acc |= int'({btn_state, btn_press, btn_release, btn_hold, btn_repeat});
    end
    #1;
    check("post_reset_quiet", acc, 0);

    // Table windows.
    for (int i = 0; i < 9; i++) begin
      PB_in     = tbl[i].pb;
      cnt_press = 0;
      cnt_rel   = 0;
      cnt_rep   = 0;
      sbq.push_back(tbl[i]);
      repeat (tbl[i].len) @(posedge clk);
      @(negedge clk);
      #1;
      e = sbq.pop_front();
      check($sformatf("row%0d_press", i),   cnt_press,        e.np);
      check($sformatf("row%0d_release", i), cnt_rel,          e.nr);
      check($sformatf("row%0d_repeat", i),  cnt_rep,          e.nrep);
      check($sformatf("row%0d_state", i),   int'(btn_state),  int'(e.st));
      check($sformatf("row%0d_hold", i),    int'(btn_hold),   int'(e.hd));
    end

    // Exact debounce latency on ch0: state at 17 edges after capture, press one later.
    run_edges(4'hE, 30, 0, ns, np, npc);
    check("ch0_state_edge", ns, 18);
    check("ch0_press_edge", np, 19);
    check("ch0_press_count", npc, 1);
    run_edges(4'hF, 30, 0, ns, np, npc);

    // Bounce ch3 every 3 clocks, then settle pressed.
    acc = 0;
    for (int s = 0; s < 16; s++) begin
      PB_in = (s % 2 == 0) ? 4'h7 : 4'hF;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        @(negedge clk);
        acc += int'(btn_press[3]) + int'(btn_state[3]);
      end
      #1;
    end
    check("bounce_no_output", acc, 0);
    run_edges(4'h7, 30, 3, ns, np, npc);
    check("ch3_settle_state_edge", ns, 18);
    check("ch3_settle_press_edge", np, 19);
    check("ch3_single_press", npc, 1);
    run_edges(4'hF, 30, 3, ns, np, npc);

    // Hold and repeat timing on ch2.
    PB_in = 4'hB;
    np = -1; nh = -1; r1 = -1; r2 = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (btn_press[2] && np < 0) np = n;
      if (btn_hold[2] && nh < 0) nh = n;
      if (btn_repeat[2]) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
    end
    #1;
    check("ch2_press_edge", np, 19);
    check("ch2_hold_edge", nh, 59);
    check("ch2_repeat1_edge", r1, 59);
    check("ch2_repeat2_edge", r2, 69);

    // Press ch0 until its counter holds 9, then reset while ch2 is held.
    PB_in = 4'hA;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("pre_reset_state", int'(btn_state), 4);
    rst = 1'b1;
    #1;
    check("async_reset_state", int'(btn_state), 0);
    check("async_reset_hold", int'(btn_hold), 0);
    check("async_reset_strobes", int'({btn_press, btn_release, btn_repeat}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ns0 = -1; ns2 = -1; pr = 0; rl = 0; acc = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (btn_state[0] && ns0 < 0) ns0 = n;
      if (btn_state[2] && ns2 < 0) ns2 = n;
      if (n <= 18) acc += $countones(btn_press);
      pr += $countones(btn_press);
      rl += $countones(btn_release);
    end
    #1;
    check("rst_ch0_restart_edge", ns0, 18);
    check("rst_ch2_restart_edge", ns2, 18);
    check("rst_no_early_press", acc, 0);
    check("rst_press_count", pr, 2);
    check("rst_no_release", rl, 0);

    check("press_release_overlap", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
